// File: rtl/aurora_simplex_init_seq.sv
// Simplex TX lane-initialisation sequencer: drives the aligned/bonded/verified/reset sideband for aurora_top.
// Optional per-state watchdog (adds watchdog_trip) is enabled by defining AURORA_INIT_WATCHDOG_EN.
module aurora_simplex_init_seq #(
    parameter int NUM_LANES       = 4,
    parameter int RESET_CYCLES    = 8,
    parameter int ALIGN_CYCLES    = 5,
    parameter int BOND_CYCLES     = 5,
    parameter int VERIFY_CYCLES   = 5,
    parameter int CNT_W           = 16,
    parameter int WATCHDOG_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         single_lane,
    input  logic [$clog2(NUM_LANES)-1:0] lane_select,
    input  logic [NUM_LANES-1:0]         lane_locked,
    input  logic                         link_err,
    output logic                         simplex_reset,
    output logic                         simplex_aligned,
    output logic                         simplex_bonded,
    output logic                         simplex_verified,
    output logic                         channel_up,
    output logic [NUM_LANES-1:0]         lane_mask,
    output logic [7:0]                   retry_cnt,
    output logic [2:0]                   state_o
`ifdef AURORA_INIT_WATCHDOG_EN
    ,
    output logic                         watchdog_trip
`endif
);

    localparam int SEL_W = $clog2(NUM_LANES);

    if (NUM_LANES < 2 || RESET_CYCLES < 1 || ALIGN_CYCLES < 1 || BOND_CYCLES < 1 ||
        VERIFY_CYCLES < 1 || WATCHDOG_CYCLES < 1 || CNT_W < 1 ||
        (CNT_W < 31 && (RESET_CYCLES >= (1 << CNT_W) || ALIGN_CYCLES >= (1 << CNT_W) ||
                        BOND_CYCLES >= (1 << CNT_W) || VERIFY_CYCLES >= (1 << CNT_W)))) begin : g_bad_params
        $error("aurora_simplex_init_seq: illegal parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RESET  = 3'd1,
        S_ALIGN  = 3'd2,
        S_BOND   = 3'd3,
        S_VERIFY = 3'd4,
        S_UP     = 3'd5
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_timer;
    logic [NUM_LANES-1:0] r_lane_mask;
    logic                 r_single;
    logic [7:0]           r_retry_cnt;
    logic                 r_simplex_reset;
    logic                 r_aligned;
    logic                 r_bonded;
    logic                 r_verified;
    logic                 r_channel_up;

    logic                 w_qual;
    logic                 w_qloss;
    logic                 w_fault;
    logic                 w_sel_invalid;
    logic [NUM_LANES-1:0] w_sel_onehot;

    // Only latched lanes are qualified; an empty mask in IDLE trivially qualifies.
    assign w_qual        = ((lane_locked & r_lane_mask) == r_lane_mask);
    assign w_qloss       = !w_qual && (r_state == S_BOND || r_state == S_VERIFY || r_state == S_UP);
    assign w_sel_invalid = ({1'b0, lane_select} >= (SEL_W + 1)'(NUM_LANES));
    assign w_sel_onehot  = NUM_LANES'(1) << lane_select;

`ifdef AURORA_INIT_WATCHDOG_EN
    localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);

    state_t               r_wd_state;
    logic [WD_W-1:0]      r_wd_cnt;
    logic                 r_wd_trip;
    logic [WD_W-1:0]      w_wd_cnt_eff;
    logic                 w_wd_hit;

    // A state change since the last edge restarts the count from zero.
    assign w_wd_cnt_eff = (r_state != r_wd_state) ? '0 : r_wd_cnt;
    assign w_wd_hit     = (r_state == S_ALIGN || r_state == S_BOND || r_state == S_VERIFY) &&
                          (w_wd_cnt_eff == WD_W'(WATCHDOG_CYCLES - 1));
    assign w_fault      = (r_state != S_RESET) && (link_err || w_qloss || w_wd_hit);
    assign watchdog_trip = r_wd_trip;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd_state <= S_IDLE;
            r_wd_cnt   <= '0;
        end else begin
            r_wd_state <= r_state;
            r_wd_cnt   <= w_wd_cnt_eff + WD_W'(1);
        end
    end
`else
    assign w_fault = (r_state != S_RESET) && (link_err || w_qloss);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_timer         <= '0;
            r_lane_mask     <= '0;
            r_single        <= 1'b0;
            r_retry_cnt     <= '0;
            r_simplex_reset <= 1'b0;
            r_aligned       <= 1'b0;
            r_bonded        <= 1'b0;
            r_verified      <= 1'b0;
            r_channel_up    <= 1'b0;
`ifdef AURORA_INIT_WATCHDOG_EN
            r_wd_trip       <= 1'b0;
`endif
        end else begin
`ifdef AURORA_INIT_WATCHDOG_EN
            r_wd_trip <= 1'b0;
`endif
            if (r_state == S_IDLE) begin
                if (start) begin
                    if (single_lane && w_sel_invalid) begin
                        r_lane_mask <= '0;
                    end else begin
                        r_lane_mask     <= single_lane ? w_sel_onehot : '1;
                        r_single        <= single_lane;
                        r_state         <= S_RESET;
                        r_timer         <= '0;
                        r_simplex_reset <= 1'b1;
                    end
                end
            end else if (!start) begin
                r_state         <= S_IDLE;
                r_timer         <= '0;
                r_lane_mask     <= '0;
                r_simplex_reset <= 1'b0;
                r_aligned       <= 1'b0;
                r_bonded        <= 1'b0;
                r_verified      <= 1'b0;
                r_channel_up    <= 1'b0;
            end else if (w_fault) begin
                r_state         <= S_RESET;
                r_timer         <= '0;
                r_simplex_reset <= 1'b1;
                r_aligned       <= 1'b0;
                r_bonded        <= 1'b0;
                r_verified      <= 1'b0;
                r_channel_up    <= 1'b0;
                if (r_retry_cnt != 8'hFF) r_retry_cnt <= r_retry_cnt + 8'd1;
`ifdef AURORA_INIT_WATCHDOG_EN
                r_wd_trip <= !(link_err || w_qloss);
`endif
            end else begin
                unique case (r_state)
                    S_RESET: begin
                        if (r_timer == CNT_W'(RESET_CYCLES - 1)) begin
                            r_state         <= S_ALIGN;
                            r_timer         <= '0;
                            r_simplex_reset <= 1'b0;
                        end else begin
                            r_timer <= r_timer + CNT_W'(1);
                        end
                    end
                    S_ALIGN: begin
                        if (!w_qual) begin
                            r_timer <= '0;
                        end else if (r_timer == CNT_W'(ALIGN_CYCLES - 1)) begin
                            r_timer   <= '0;
                            r_aligned <= 1'b1;
                            if (r_single) begin
                                r_bonded <= 1'b1;
                                r_state  <= S_VERIFY;
                            end else begin
                                r_state  <= S_BOND;
                            end
                        end else begin
                            r_timer <= r_timer + CNT_W'(1);
                        end
                    end
                    S_BOND: begin
                        if (r_timer == CNT_W'(BOND_CYCLES - 1)) begin
                            r_state  <= S_VERIFY;
                            r_timer  <= '0;
                            r_bonded <= 1'b1;
                        end else begin
                            r_timer <= r_timer + CNT_W'(1);
                        end
                    end
                    S_VERIFY: begin
                        if (r_timer == CNT_W'(VERIFY_CYCLES - 1)) begin
                            r_state      <= S_UP;
                            r_timer      <= '0;
                            r_verified   <= 1'b1;
                            r_channel_up <= 1'b1;
                        end else begin
                            r_timer <= r_timer + CNT_W'(1);
                        end
                    end
                    S_UP: begin
                        r_channel_up <= 1'b1;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_timer <= '0;
                    end
                endcase
            end
        end
    end

    assign simplex_reset    = r_simplex_reset;
    assign simplex_aligned  = r_aligned;
    assign simplex_bonded   = r_bonded;
    assign simplex_verified = r_verified;
    assign channel_up       = r_channel_up;
    assign lane_mask        = r_lane_mask;
    assign retry_cnt        = r_retry_cnt;
    assign state_o          = r_state;

endmodule

// File: tb/tb_aurora_simplex_init_seq.sv
// Self-checking bench for aurora_simplex_init_seq: table-driven bring-up vectors, directed corner
// sequences and randomized stimulus against a stage/elapsed-time model of the sequencing rules.
module tb_aurora_simplex_init_seq;

    localparam int NUM_LANES     = 4;
    localparam int RESET_CYCLES  = 8;
    localparam int ALIGN_CYCLES  = 5;
    localparam int BOND_CYCLES   = 5;
    localparam int VERIFY_CYCLES = 5;
`ifdef AURORA_INIT_WATCHDOG_EN
    localparam int WD_TB = 16;
`else
    localparam int WD_TB = 1024;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       singleLane = 1'b0;
    logic [1:0] laneSelect = 2'd0;
    logic [3:0] laneLocked = 4'h0;
    logic       linkErr = 1'b0;

    logic       simplexReset, simplexAligned, simplexBonded, simplexVerified, channelUp;
    logic [3:0] laneMask;
    logic [7:0] retryCnt;
    logic [2:0] stateO;
`ifdef AURORA_INIT_WATCHDOG_EN
    logic       watchdogTrip;
`endif

    int assertions = 0;
    int failures = 0;

    int         mStage = 0;
    int         mElapsed = 0;
    int         mWd = 0;
    int         mRetry = 0;
    logic [3:0] mMask = 4'h0;
    bit         mSingle = 1'b0;
    bit         mTrip = 1'b0;

    always #5 clk = ~clk;

    aurora_simplex_init_seq #(
        .NUM_LANES(NUM_LANES), .RESET_CYCLES(RESET_CYCLES), .ALIGN_CYCLES(ALIGN_CYCLES),
        .BOND_CYCLES(BOND_CYCLES), .VERIFY_CYCLES(VERIFY_CYCLES), .CNT_W(16),
        .WATCHDOG_CYCLES(WD_TB)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .single_lane(singleLane),
        .lane_select(laneSelect), .lane_locked(laneLocked), .link_err(linkErr),
        .simplex_reset(simplexReset), .simplex_aligned(simplexAligned),
        .simplex_bonded(simplexBonded), .simplex_verified(simplexVerified),
        .channel_up(channelUp), .lane_mask(laneMask), .retry_cnt(retryCnt),
        .state_o(stateO)
`ifdef AURORA_INIT_WATCHDOG_EN
        , .watchdog_trip(watchdogTrip)
`endif
    );

    // Nominal duration of each timed stage: 1 reset, 3 bond, 4 verify.
    function automatic int stageLen(input int s);
        case (s)
            1:       return RESET_CYCLES;
            3:       return BOND_CYCLES;
            4:       return VERIFY_CYCLES;
            default: return 0;
        endcase
    endfunction

    // Reference model: stage number plus cycles spent in it; outputs follow from stage alone.
    task automatic modelStep();
        int  prev = mStage;
        bit  q = ((laneLocked & mMask) == mMask);
        bit  qLoss = (mStage >= 3) && !q;
        bit  wdHit = 1'b0;
        mTrip = 1'b0;
`ifdef AURORA_INIT_WATCHDOG_EN
        wdHit = (mStage >= 2 && mStage <= 4) && (mWd + 1 == WD_TB);
`endif
        if (rst) begin
            mStage = 0; mMask = 4'h0; mRetry = 0;
        end else if (mStage == 0) begin
            if (start) begin
                if (singleLane && int'(laneSelect) >= NUM_LANES) begin
                    mMask = 4'h0;
                end else begin
                    mMask = singleLane ? (4'(1) << laneSelect) : 4'hF;
                    mSingle = singleLane;
                    mStage = 1;
                end
            end
        end else if (!start) begin
            mStage = 0; mMask = 4'h0;
        end else if (mStage != 1 && (linkErr || qLoss || wdHit)) begin
            if (mRetry < 255) mRetry++;
            mTrip = !(linkErr || qLoss);
            mStage = 1;
        end else if (mStage == 2) begin
            if (!q) mElapsed = 0;
            else begin
                mElapsed++;
                if (mElapsed == ALIGN_CYCLES) mStage = mSingle ? 4 : 3;
            end
        end else if (mStage != 5) begin
            mElapsed++;
            if (mElapsed == stageLen(mStage)) mStage++;
        end
        if (rst || mStage != prev) begin
            mElapsed = 0; mWd = 0;
        end else begin
            mWd++;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic sl, input logic [1:0] sel,
                                 input logic [3:0] lk, input logic le);
        rst = r; start = s; singleLane = sl; laneSelect = sel; laneLocked = lk; linkErr = le;
    endtask

    // One clock: advance the model at the edge, then compare every output just after it.
    task automatic tick();
        logic [19:0] act, exp;
        @(posedge clk);
        modelStep();
        #1;
        act = {stateO, simplexReset, simplexAligned, simplexBonded, simplexVerified, channelUp, laneMask, retryCnt};
        exp = {3'(mStage), mStage == 1, mStage >= 3, mStage >= 4, mStage == 5, mStage == 5, mMask, 8'(mRetry)};
        checkOutput("model", 32'(act), 32'(exp));
`ifdef AURORA_INIT_WATCHDOG_EN
        checkOutput("wdTripModel", 32'(watchdogTrip), 32'(mTrip));
`endif
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Waits up to the bound for channel_up; returns 0 if it never rose.
    task automatic waitUp(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (channelUp) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    typedef struct {
        bit         single;
        logic [1:0] sel;
        logic [3:0] locked;
        logic [3:0] mask;
        int         alignAt;
        int         bondAt;
        int         upAt;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int  aAt, bAt, uAt, rstHigh, c;
        bit  ok;

        vecs[0] = '{1'b0, 2'd0, 4'hF,    4'hF,    14, 19, 24};
        vecs[1] = '{1'b1, 2'd2, 4'b0100, 4'b0100, 14, 14, 19};
        vecs[2] = '{1'b1, 2'd0, 4'b0001, 4'b0001, 14, 14, 19};
        vecs[3] = '{1'b1, 2'd3, 4'b1000, 4'b1000, 14, 14, 19};
        vecs[4] = '{1'b0, 2'd3, 4'hF,    4'hF,    14, 19, 24};
        vecs[5] = '{1'b1, 2'd1, 4'b0110, 4'b0010, 14, 14, 19};

        doReset();
        checkOutput("resetState", 32'({stateO, simplexReset, simplexAligned, simplexBonded,
                    simplexVerified, channelUp, laneMask, retryCnt}), 32'd0);

        foreach (vecs[i]) begin
            doReset();
            applyStimulus(1'b0, 1'b1, vecs[i].single, vecs[i].sel, vecs[i].locked, 1'b0);
            aAt = 0; bAt = 0; uAt = 0; rstHigh = 0;
            for (int cyc = 1; cyc <= 60; cyc++) begin
                tick();
                if (simplexReset) rstHigh++;
                if (simplexAligned && aAt == 0) aAt = cyc;
                if (simplexBonded && bAt == 0) bAt = cyc;
                if (channelUp) begin
                    uAt = cyc;
                    break;
                end
            end
            checkOutput($sformatf("alignAt[%0d]", i), 32'(aAt), 32'(vecs[i].alignAt));
            checkOutput($sformatf("bondAt[%0d]", i), 32'(bAt), 32'(vecs[i].bondAt));
            checkOutput($sformatf("upAt[%0d]", i), 32'(uAt), 32'(vecs[i].upAt));
            checkOutput($sformatf("mask[%0d]", i), 32'(laneMask), 32'(vecs[i].mask));
            checkOutput($sformatf("resetLen[%0d]", i), 32'(rstHigh), 32'(RESET_CYCLES));
            checkOutput($sformatf("retry[%0d]", i), 32'(retryCnt), 32'd0);
        end

        // Lock glitch on lane 1 after three qualified ALIGN cycles.
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 4'hF, 1'b0);
        for (int k = 0; k < 12; k++) tick();
        laneLocked = 4'b1101;
        tick();
        laneLocked = 4'hF;
        aAt = 0;
        for (int cyc = 14; cyc <= 60; cyc++) begin
            tick();
            if (simplexAligned) begin
                aAt = cyc;
                break;
            end
        end
        checkOutput("glitchAlignAt", 32'(aAt), 32'd18);
        checkOutput("glitchRetry", 32'(retryCnt), 32'd0);

        // link_err in UP, then repeated until the retry counter saturates.
        doReset();
        start = 1'b1;
        laneLocked = 4'hF;
        for (int n = 1; n <= 300; n++) begin
            waitUp(ok);
            if (!ok) begin
                checkOutput("upTimeout", 32'd0, 32'd1);
                break;
            end
            linkErr = 1'b1;
            tick();
            linkErr = 1'b0;
            if (n == 1) begin
                checkOutput("errState", 32'(stateO), 32'd1);
                checkOutput("errFlags", 32'({simplexAligned, simplexBonded, simplexVerified, channelUp}), 32'd0);
                checkOutput("errRetry1", 32'(retryCnt), 32'd1);
            end
        end
        checkOutput("retrySat", 32'(retryCnt), 32'd255);

        // Mid-operation reset during VERIFY.
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 4'hF, 1'b0);
        for (int k = 0; k < 21; k++) tick();
        checkOutput("inVerify", 32'(stateO), 32'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midRst", 32'({stateO, simplexReset, simplexAligned, simplexBonded,
                    simplexVerified, channelUp, laneMask, retryCnt}), 32'd0);

        // start=0 takes priority over a simultaneous link_err.
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 4'hF, 1'b0);
        for (int k = 0; k < 10; k++) tick();
        linkErr = 1'b1;
        tick();
        linkErr = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        start = 1'b0;
        linkErr = 1'b1;
        tick();
        linkErr = 1'b0;
        checkOutput("stopState", 32'(stateO), 32'd0);
        checkOutput("stopRetry", 32'(retryCnt), 32'd1);
        checkOutput("stopMask", 32'(laneMask), 32'd0);

`ifdef AURORA_INIT_WATCHDOG_EN
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0);
        for (int k = 0; k < 9; k++) tick();
        for (int k = 0; k < 15; k++) tick();
        checkOutput("wdEarly", 32'(watchdogTrip), 32'd0);
        tick();
        checkOutput("wdTrip", 32'(watchdogTrip), 32'd1);
        checkOutput("wdState", 32'(stateO), 32'd1);
        checkOutput("wdRetry", 32'(retryCnt), 32'd1);
        tick();
        checkOutput("wdPulse", 32'(watchdogTrip), 32'd0);
`endif

        // Randomized stimulus against the model.
        doReset();
        start = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 499) == 0);
            if (!start) start = ($urandom_range(0, 3) == 0);
            else start = ($urandom_range(0, 199) != 0);
            singleLane = $urandom_range(0, 1);
            laneSelect = 2'($urandom_range(0, 3));
            laneLocked = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            linkErr = ($urandom_range(0, 149) == 0);
            tick();
        end
        c = assertions;

        $display("[TB] %0d cycles of random stimulus compared", 3000);
        $display("End of test - %0d assertions evaluated, %0d failures", c, failures);
        $finish;
    end

endmodule
